uart_tx_multi: RTL and testbench
================================

Name: uart_tx_multi

Overview:
- Parametrised multi-byte UART transmitter; next generation of the fixed 36-byte/8-bit/10-clock transmitter.
- Captures a wide payload on a send request and serialises a runtime-selectable number of bytes as standard async frames on one serial line.
- Frame: start 0, data bits, optional parity, stop 1s.
- Sits between the packet-assembly logic and the board TX pin.
- Adds a busy/done handshake, variable length, configurable framing and baud divisor.

Parameters:
- NUM_BYTES, 36, maximum payload bytes held in the capture register.
- DATA_BITS, 8, data bits per frame (5..9).
- CLKS_PER_BIT, 10, clk cycles per serial bit period (>=2).
- STOP_BITS, 1, stop bits per frame (1 or 2).
- MSB_FIRST, 1, 1 = each byte sent MSB first; 0 = LSB first.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- tx_data  input  NUM_BYTES*DATA_BITS  payload; byte k = tx_data[k*DATA_BITS +: DATA_BITS].
- tx_len  input  $clog2(NUM_BYTES+1)  number of bytes to send, 0..NUM_BYTES.
- send_data  input  1  request; sampled every cycle.
- serial_out  output  1  serial line, idle high.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (asynchronous, any time including mid-frame):
  - serial_out=1, busy=0, done=0.
  - FSM returns to IDLE; counters clear.
  - Any partial frame is abandoned and never resumed.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP.
- IDLE:
  - If send_data=1 and tx_len!=0: capture tx_data and tx_len, byte index = tx_len-1, then go to START on the next edge.
  - If send_data=1 and tx_len=0: no bits are sent; done pulses the next cycle; busy stays 0.
- Acceptance is the only capture point. tx_data and tx_len changes while busy have no effect.
- send_data while busy is ignored; no queueing.
- Byte order: highest-indexed captured byte first (byte tx_len-1 down to byte 0). Bit order is set by MSB_FIRST.
- Each bit is held exactly CLKS_PER_BIT cycles. The bit timer counts 0..CLKS_PER_BIT-1, and the state/bit advances on the terminal count.
- START: serial_out=0, then DATA.
- DATA: DATA_BITS bit periods, then PARITY (if enabled) or STOP.
- STOP: serial_out=1 for STOP_BITS periods. Then:
  - If bytes remain: decrement the byte index and go to START, with no idle gap between frames.
  - Otherwise: go to IDLE.
- serial_out is registered. It goes low the first cycle after the accepting edge.
- Total busy cycles = tx_len*(1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT, where P = 1 with parity and 0 without.
- busy rises on the accepting edge and falls on the edge entering IDLE.
- done is high in the first IDLE cycle only.
- A send_data high in that same cycle is accepted: back-to-back transfers have zero gap.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; serial_out = XOR of the data bits (even parity) for one bit period.
  - Extra input port parity_odd (1 bit, sampled at acceptance) inverts the parity bit.
- Undefined: no PARITY state, no parity_odd port; frame = 1+DATA_BITS+STOP_BITS bits.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - Function frame_bits(DATA_BITS, STOP_BITS, parity) returning bits per frame.
- Bit-period timer: instantiate the existing flex_counter (width $clog2(CLKS_PER_BIT)), cleared on acceptance. No new timer module.
- One sub-module is natural: uart_tx_fsm (state, bit counter, byte index, busy/done). The datapath shift/select stays in uart_tx_multi.

Test Plan (NUM_BYTES=4, DATA_BITS=8, CLKS_PER_BIT=4, STOP_BITS=1, MSB_FIRST=1 unless noted):
- Single byte: tx_data[7:0]=8'hA5, tx_len=1, pulse send_data.
  - serial_out = 0,1,0,1,0,0,1,0,1,1 bits, each held 4 cycles.
  - busy high 40 cycles, then done pulses once.
- Multi-byte: tx_data=32'h11223344, tx_len=3.
  - Frames sent in order 0x22, 0x11? No: 0x22 is byte 2? Order is byte 2 (0x22), byte 1 (0x33), byte 0 (0x44); 0x11 is never sent.
  - No idle gap between frames; busy 120 cycles.
- Busy and back-to-back: send_data re-pulsed mid-transfer is ignored. send_data held high through done starts a second transfer on the next edge; serial_out shows no idle-high bit between transfers.
- Reset mid-frame: assert n_rst low during the DATA state of byte 2.
  - serial_out=1 and busy=0 immediately, without a clock edge.
  - After release, the line stays idle until a new send_data.
- Edge cases:
  - tx_len=0 → done pulse one cycle later, serial_out stays 1.
  - MSB_FIRST=0 with 8'h01 → first data bit 1.
- UART_TX_PARITY_EN defined: 8'h07 with parity_odd=0 → parity bit 1; with parity_odd=1 → parity bit 0; frame = 11 bits = 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the multi-byte UART transmitter.
//   tx_state_t  - transmitter FSM state (IDLE, START, DATA, PARITY, STOP)
//   PARITY_EN   - 1 when UART_TX_PARITY_EN is defined at build time
//   frame_bits  - serial bit periods in one frame
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_t;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int unsigned frame_bits(int unsigned data_bits,
                                             int unsigned stop_bits,
                                             bit parity);
    return 1 + data_bits + (parity ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_multi_if.sv
// uart_tx_multi_if: request/handshake bundle between packet assembly (master)
// and the UART transmitter (slave).
//   tx_data    payload, byte k = tx_data[k*DATA_BITS +: DATA_BITS]
//   tx_len     number of bytes to send (0..NUM_BYTES)
//   send_data  transfer request, sampled every cycle
//   parity_odd odd-parity select (only with UART_TX_PARITY_EN)
//   busy       transfer in progress
//   done       one-cycle completion pulse
interface uart_tx_multi_if #(
  parameter int unsigned NUM_BYTES = 36,
  parameter int unsigned DATA_BITS = 8
);
  logic [NUM_BYTES*DATA_BITS-1:0]  tx_data;
  logic [$clog2(NUM_BYTES+1)-1:0]  tx_len;
  logic                            send_data;
  logic                            busy;
  logic                            done;

`ifdef UART_TX_PARITY_EN
  logic parity_odd;
  modport master (output tx_data, tx_len, send_data, parity_odd, input busy, done);
  modport slave  (input tx_data, tx_len, send_data, parity_odd, output busy, done);
`else
  modport master (output tx_data, tx_len, send_data, input busy, done);
  modport slave  (input tx_data, tx_len, send_data, output busy, done);
`endif
endinterface

// File: rtl/flex_counter.sv
// flex_counter: generic up-counter wrapping from rollover_val back to 0.
//   clk, n_rst    clock, async active-low reset
//   clear         synchronous clear to 0 (wins over count_enable)
//   count_enable  advance one step
//   rollover_val  terminal count
//   count_out     current count
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) count_out <= '0;
      else                           count_out <= count_out + NUM_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: frame sequencing for uart_tx_multi.
//   clk, n_rst  clock, async active-low reset
//   send_data   request; tx_len bytes to send
//   tick        last cycle of the current bit period
//   accept      request accepted this cycle (capture strobe)
//   state_nxt, pos_nxt, byte_nxt  values the FSM takes at the next edge
//   busy, done  handshake outputs (registered)
// pos counts bit periods within a frame: 0 = start, 1..DATA_BITS = data,
// then parity (UART_TX_PARITY_EN builds), then stop bits.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 36,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  localparam int unsigned LEN_W = $clog2(NUM_BYTES + 1),
  localparam int unsigned POS_W = $clog2(frame_bits(DATA_BITS, STOP_BITS, PARITY_EN))
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             send_data,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             tick,
  output logic             accept,
  output tx_state_t        state_nxt,
  output logic [POS_W-1:0] pos_nxt,
  output logic [LEN_W-1:0] byte_nxt,
  output logic             busy,
  output logic             done
);

  localparam logic [POS_W-1:0] POS_LAST =
    POS_W'(frame_bits(DATA_BITS, STOP_BITS, PARITY_EN) - 1);

  tx_state_t        state;
  logic [POS_W-1:0] pos;
  logic [LEN_W-1:0] byte_idx;
  logic             done_nxt;

  function automatic tx_state_t state_at(logic [POS_W-1:0] p);
    if (p == '0)                                    return START;
    else if (p <= POS_W'(DATA_BITS))                return DATA;
    else if (PARITY_EN && p == POS_W'(DATA_BITS + 1)) return PARITY;
    else                                            return STOP;
  endfunction

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    byte_nxt  = byte_idx;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (send_data) begin
          if (tx_len != '0) begin
            accept    = 1'b1;
            state_nxt = START;
            pos_nxt   = '0;
            byte_nxt  = tx_len - LEN_W'(1);
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (tick) begin
          if (pos == POS_LAST) begin
            pos_nxt = '0;
            if (byte_idx != '0) begin
              byte_nxt  = byte_idx - LEN_W'(1);
              state_nxt = START;
            end else begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            pos_nxt   = pos + POS_W'(1);
            state_nxt = state_at(pos + POS_W'(1));
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      pos      <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      byte_idx <= byte_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
    end
  end

endmodule

// File: rtl/uart_tx_multi.sv
// uart_tx_multi: parametrised multi-byte UART transmitter.
//   clk, n_rst  clock, async active-low reset
//   bus         uart_tx_multi_if.slave (tx_data, tx_len, send_data, busy, done
//               and parity_odd when UART_TX_PARITY_EN is defined)
//   serial_out  registered serial line, idle high
// Bytes go out highest captured index first; bit order set by MSB_FIRST.
// Build option: UART_TX_PARITY_EN adds an even/odd parity bit after the data.
module uart_tx_multi
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES    = 36,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_FIRST    = 1
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_tx_multi_if.slave bus,
  output logic           serial_out
);

  localparam int unsigned LEN_W = $clog2(NUM_BYTES + 1);
  localparam int unsigned POS_W = $clog2(frame_bits(DATA_BITS, STOP_BITS, PARITY_EN));
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                           accept;
  logic                           tick;
  tx_state_t                      state_nxt;
  logic [POS_W-1:0]               pos_nxt;
  logic [LEN_W-1:0]               byte_nxt;
  logic [CNT_W-1:0]               bit_timer;
  logic [NUM_BYTES*DATA_BITS-1:0] cap_data;
  logic [DATA_BITS-1:0]           sel_byte;
  logic [POS_W-1:0]               bit_pos;
  logic                           data_bit;
  logic                           line_nxt;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (accept),
    .count_enable (bus.busy),
    .rollover_val (CNT_LAST),
    .count_out    (bit_timer)
  );

  assign tick = bus.busy && (bit_timer == CNT_LAST);

  uart_tx_fsm #(
    .NUM_BYTES (NUM_BYTES),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS)
  ) u_fsm (
    .clk       (clk),
    .n_rst     (n_rst),
    .send_data (bus.send_data),
    .tx_len    (bus.tx_len),
    .tick      (tick),
    .accept    (accept),
    .state_nxt (state_nxt),
    .pos_nxt   (pos_nxt),
    .byte_nxt  (byte_nxt),
    .busy      (bus.busy),
    .done      (bus.done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      cap_data <= '0;
    else if (accept) cap_data <= bus.tx_data;
  end

`ifdef UART_TX_PARITY_EN
  logic par_odd_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      par_odd_q <= 1'b0;
    else if (accept) par_odd_q <= bus.parity_odd;
  end
`endif

  // The line level is computed from the FSM's next-cycle position so that
  // serial_out stays a plain register yet changes on the same edge as state.
  always_comb begin
    sel_byte = DATA_BITS'(cap_data >> (32'(byte_nxt) * DATA_BITS));
    if (MSB_FIRST != 0) bit_pos = POS_W'(DATA_BITS) - pos_nxt;
    else                bit_pos = pos_nxt - POS_W'(1);
    data_bit = |(sel_byte & (DATA_BITS'(1) << bit_pos));
    case (state_nxt)
      START:   line_nxt = 1'b0;
      DATA:    line_nxt = data_bit;
`ifdef UART_TX_PARITY_EN
      PARITY:  line_nxt = (^sel_byte) ^ par_odd_q;
`endif
      default: line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) serial_out <= 1'b1;
    else        serial_out <= line_nxt;
  end

endmodule

// File: tb/tb_uart_tx_multi.sv
// tb_uart_tx_multi: scoreboard bench for uart_tx_multi (4 bytes, 8 data bits,
// 4 clocks per bit, 1 stop bit). u_msb sends MSB first, u_lsb LSB first.
// Each cycle's expected (serial_out, busy, done) is queued when a request is
// seen in an idle cycle and compared cycle by cycle on the falling clock edge.
module tb_uart_tx_multi;

  localparam int CLKS = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FB = 1 + 8 + PAR + 1;

  typedef struct packed {
    logic line;
    logic busy;
    logic done;
  } entry_t;

  localparam entry_t IDLE_E = '{line: 1'b1, busy: 1'b0, done: 1'b0};

  logic clk;
  logic n_rst;
  logic line0, line1;
  int   vectors;
  int   miscompares;
  int   cyc;
  entry_t q0[$];
  entry_t q1[$];

  uart_tx_multi_if #(.NUM_BYTES(4), .DATA_BITS(8)) bus0 ();
  uart_tx_multi_if #(.NUM_BYTES(4), .DATA_BITS(8)) bus1 ();

  uart_tx_multi #(
    .NUM_BYTES(4), .DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(1)
  ) u_msb (
    .clk(clk), .n_rst(n_rst), .bus(bus0.slave), .serial_out(line0)
  );

  uart_tx_multi #(
    .NUM_BYTES(4), .DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(0)
  ) u_lsb (
    .clk(clk), .n_rst(n_rst), .bus(bus1.slave), .serial_out(line1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic void push_e(int inst, entry_t e);
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
  endfunction

  // Expected per-cycle trace of one accepted transfer, starting the cycle
  // after the accepting edge and ending with the done cycle.
  function automatic void push_xfer(int inst, logic [31:0] data, int len,
                                    logic odd, bit msb);
    logic [7:0] b;
    logic [7:0] sh;
    logic       bitv;
    for (int k = len - 1; k >= 0; k--) begin
      b = data[k*8 +: 8];
      for (int p = 0; p < FB; p++) begin
        if (p == 0) begin
          bitv = 1'b0;
        end else if (p <= 8) begin
          sh   = msb ? (b >> (8 - p)) : (b >> (p - 1));
          bitv = sh[0];
        end else if (PAR == 1 && p == 9) begin
          bitv = (^b) ^ odd;
        end else begin
          bitv = 1'b1;
        end
        for (int c = 0; c < CLKS; c++)
          push_e(inst, '{line: bitv, busy: 1'b1, done: 1'b0});
      end
    end
    push_e(inst, '{line: 1'b1, busy: 1'b0, done: 1'b1});
  endfunction

  always @(negedge clk) begin
    entry_t e;
    logic   odd;
    if (n_rst) begin
      if (q0.size() > 0) e = q0.pop_front();
      else               e = IDLE_E;
      check($sformatf("line0@%0d", cyc), line0, e.line);
      check($sformatf("busy0@%0d", cyc), bus0.busy, e.busy);
      check($sformatf("done0@%0d", cyc), bus0.done, e.done);
`ifdef UART_TX_PARITY_EN
      odd = bus0.parity_odd;
`else
      odd = 1'b0;
`endif
      if (!e.busy && bus0.send_data)
        push_xfer(0, bus0.tx_data, int'(bus0.tx_len), odd, 1'b1);
    end
  end

  always @(negedge clk) begin
    entry_t e;
    logic   odd;
    if (n_rst) begin
      if (q1.size() > 0) e = q1.pop_front();
      else               e = IDLE_E;
      check($sformatf("line1@%0d", cyc), line1, e.line);
      check($sformatf("busy1@%0d", cyc), bus1.busy, e.busy);
      check($sformatf("done1@%0d", cyc), bus1.done, e.done);
`ifdef UART_TX_PARITY_EN
      odd = bus1.parity_odd;
`else
      odd = 1'b0;
`endif
      if (!e.busy && bus1.send_data)
        push_xfer(1, bus1.tx_data, int'(bus1.tx_len), odd, 1'b0);
    end
  end

  task automatic pulse(input int inst, input logic [31:0] data,
                       input logic [2:0] len, input logic odd);
    @(posedge clk); #1;
    if (inst == 0) begin
      bus0.tx_data = data; bus0.tx_len = len; bus0.send_data = 1'b1;
`ifdef UART_TX_PARITY_EN
      bus0.parity_odd = odd;
`endif
    end else begin
      bus1.tx_data = data; bus1.tx_len = len; bus1.send_data = 1'b1;
`ifdef UART_TX_PARITY_EN
      bus1.parity_odd = odd;
`endif
    end
    @(posedge clk); #1;
    bus0.send_data = 1'b0;
    bus1.send_data = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    if (q0.size() != 0 || q1.size() != 0) check("drain_timeout", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    bit seen;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    n_rst = 1'b0;
    bus0.tx_data = '0; bus0.tx_len = '0; bus0.send_data = 1'b0;
    bus1.tx_data = '0; bus1.tx_len = '0; bus1.send_data = 1'b0;
`ifdef UART_TX_PARITY_EN
    bus0.parity_odd = 1'b0;
    bus1.parity_odd = 1'b0;
`endif
    #22;
    check("rst_line0", line0, 1'b1);
    check("rst_busy0", bus0.busy, 1'b0);
    check("rst_done0", bus0.done, 1'b0);
    check("rst_line1", line1, 1'b1);
    @(posedge clk); #2;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);

    // Single byte.
    pulse(0, 32'h0000_00A5, 3'd1, 1'b0);
    wait_idle(200);

    // Three bytes; a mid-transfer request with new data must be ignored.
    pulse(0, 32'h1122_3344, 3'd3, 1'b0);
    repeat (30) @(posedge clk);
    pulse(0, 32'hDEAD_BEEF, 3'd4, 1'b0);
    wait_idle(400);

    // Request held high through done: second transfer starts with no gap.
    @(posedge clk); #1;
    bus0.tx_data = 32'h0000_C3F0; bus0.tx_len = 3'd2; bus0.send_data = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (bus0.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b_done_seen", seen, 1'b1);
    bus0.tx_data = 32'h0000_005A; bus0.tx_len = 3'd1;
    @(posedge clk); #1;
    bus0.send_data = 1'b0;
    wait_idle(400);

    // Zero-length request.
    pulse(0, 32'hFFFF_FFFF, 3'd0, 1'b0);
    wait_idle(20);

    // Reset during the data bits of the first frame.
    pulse(0, 32'h00A5_5AFF, 3'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    n_rst = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    check("midrst_line0", line0, 1'b1);
    check("midrst_busy0", bus0.busy, 1'b0);
    check("midrst_done0", bus0.done, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (20) @(posedge clk);

    // LSB-first instance.
    pulse(1, 32'h0000_0001, 3'd1, 1'b0);
    wait_idle(200);
    pulse(1, 32'h0000_3C81, 3'd2, 1'b0);
    wait_idle(300);

`ifdef UART_TX_PARITY_EN
    pulse(0, 32'h0000_0007, 3'd1, 1'b0);
    wait_idle(200);
    pulse(0, 32'h0000_0007, 3'd1, 1'b1);
    wait_idle(200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
